// File: rtl/regfile_wbq_pkg.sv
// rtl/regfile_wbq_pkg.sv - shared constants, entry type and width helpers for the write-back queue
// Purpose: default geometry of the register write-back queue, the entry
//          record {register index, data} and helpers that derive pointer and
//          occupancy-counter widths from a depth.
// Ports:   none (package)
package regfile_wbq_pkg;

  localparam int DEF_DEPTH  = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] rg;
    logic [DEF_DATA_W-1:0] data;
  } wbq_entry_t;

  // Pointer width; a depth of 1 would give 0 bits, so clamp to 1.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEF_PTR_W = ptr_w(DEF_DEPTH);
  localparam int DEF_CNT_W = cnt_w(DEF_DEPTH);

endpackage

// File: rtl/wbq_bypass_match.sv
// rtl/wbq_bypass_match.sv - youngest-match search of pending entries for one read port
// Purpose: compares a read index against every valid queue entry and returns
//          the data of the youngest match. Only instantiated when
//          REGFILE_WBQ_BYPASS_EN is defined.
// Ports:   ent_reg_i/ent_data_i  entry storage (index / data)
//          ent_valid_i           per-slot occupancy mask
//          tail_i                next write slot (youngest entry is tail_i-1)
//          rd_reg_i              read index; index 0 never matches
//          hit_o/hit_data_o      match flag and youngest matching data (0 on miss)
module wbq_bypass_match
  import regfile_wbq_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PTR_W  = ptr_w(DEPTH)
) (
  input  logic [ADDR_W-1:0] ent_reg_i  [DEPTH],
  input  logic [DATA_W-1:0] ent_data_i [DEPTH],
  input  logic [DEPTH-1:0]  ent_valid_i,
  input  logic [PTR_W-1:0]  tail_i,
  input  logic [ADDR_W-1:0] rd_reg_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] hit_data_o
);

  // Walk from the oldest slot (tail-DEPTH) to the youngest (tail-1) so the
  // last match written is the youngest one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail_i - PTR_W'(k);
      if ((rd_reg_i != '0) && ent_valid_i[idx] && (ent_reg_i[idx] == rd_reg_i)) begin
        hit_o      = 1'b1;
        hit_data_o = ent_data_i[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - register write-back queue feeding the single register-file write port
// Purpose: buffers write-back requests and issues one per cycle to the
//          register file; optional read-port bypass of pending entries when
//          the macro REGFILE_WBQ_BYPASS_EN is defined (otherwise Hit*/HitData*
//          are tied to 0 and ReadReg* are ignored).
// Ports:   clk, rst_n                  clock, async active-low reset
//          InValid/InReady/InReg/InData request handshake and payload
//          WrStall                      holds the head entry this cycle
//          RegWr/WriteReg/WriteData     register-file write port
//          ReadReg1/2, Hit1/2, HitData1/2 bypass lookup
//          Count, Full, Empty           occupancy
module regfile_write_queue
  import regfile_wbq_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [ADDR_W-1:0]          InReg,
  input  logic [DATA_W-1:0]          InData,
  input  logic                       WrStall,
  output logic                       RegWr,
  output logic [ADDR_W-1:0]          WriteReg,
  output logic [DATA_W-1:0]          WriteData,
  input  logic [ADDR_W-1:0]          ReadReg1,
  input  logic [ADDR_W-1:0]          ReadReg2,
  output logic                       Hit1,
  output logic                       Hit2,
  output logic [DATA_W-1:0]          HitData1,
  output logic [DATA_W-1:0]          HitData2,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Full,
  output logic                       Empty
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [ADDR_W-1:0] ent_reg_q  [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, empty, push, pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  // Derived from the count register only, so a pop on the same edge cannot
  // make room for a push; readiness returns the cycle after the pop.
  assign InReady = !full;
  assign Full    = full;
  assign Empty   = empty;
  assign Count   = count_q;

  // Index-0 writes finish the handshake but are dropped on the floor.
  assign push = InValid && InReady && (InReg != '0);
  assign RegWr = !empty && !WrStall;
  assign pop   = RegWr;

  assign WriteReg  = empty ? '0 : ent_reg_q[head_q];
  assign WriteData = empty ? '0 : ent_data_q[head_q];

  always_comb begin
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg_q[tail_q]  <= InReg;
      ent_data_q[tail_q] <= InData;
    end
  end

`ifdef REGFILE_WBQ_BYPASS_EN
  logic [PTR_W-1:0] ent_off [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  // A slot is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_off[i]   = PTR_W'(i) - head_q;
      ent_valid[i] = (CNT_W'(ent_off[i]) < count_q);
    end
  end

  wbq_bypass_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PTR_W(PTR_W)) u_match1 (
    .ent_reg_i   (ent_reg_q),
    .ent_data_i  (ent_data_q),
    .ent_valid_i (ent_valid),
    .tail_i      (tail_q),
    .rd_reg_i    (ReadReg1),
    .hit_o       (Hit1),
    .hit_data_o  (HitData1)
  );

  wbq_bypass_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PTR_W(PTR_W)) u_match2 (
    .ent_reg_i   (ent_reg_q),
    .ent_data_i  (ent_data_q),
    .ent_valid_i (ent_valid),
    .tail_i      (tail_q),
    .rd_reg_i    (ReadReg2),
    .hit_o       (Hit2),
    .hit_data_o  (HitData2)
  );
`else
  logic unused_rd;
  assign unused_rd = ^{ReadReg1, ReadReg2};
  assign Hit1      = 1'b0;
  assign Hit2      = 1'b0;
  assign HitData1  = '0;
  assign HitData2  = '0;
`endif

endmodule
